// File: rtl/truth_table_checker.sv
// Truth-table response checker: consumes (vector, output) samples over valid/ready and grades a sweep.
// Optional build macro TTC_ANY_ORDER_EN: samples may arrive in any order, duplicates flag seq_err.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | after reset, no sweep started, s_ready low
// RUN   | sweep in progress, one sample accepted per valid&ready
// DONE  | 2**N_IN samples accepted, results held until start/reset
module truth_table_checker #(
   parameter int unsigned             N_IN  = 4,
   parameter logic [(2**N_IN)-1:0]    TT    = 16'h8000,
   parameter int unsigned             ERR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [N_IN-1:0]   s_vec,
   input  logic              s_out,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic [ERR_W-1:0]  err_cnt,
   output logic              seq_err,
   output logic [N_IN-1:0]   first_err_vec
);

   localparam int unsigned      N_VEC    = 2**N_IN;
   localparam logic [N_IN-1:0]  IDX_LAST = {N_IN{1'b1}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   logic [N_IN-1:0]     idx;
   logic                accept;
   logic                mismatch;
   logic [ERR_W-1:0]    err_nxt;
   logic [N_IN-1:0]     first_nxt;
   logic                seq_nxt;
   logic                pass_nxt;

`ifdef TTC_ANY_ORDER_EN
   logic [N_VEC-1:0]    seen;
   logic [N_VEC-1:0]    seen_nxt;
`endif

   // s_ready is a register mirroring RUN, so accept has no path from s_valid back to s_ready
   assign accept = s_valid & s_ready;

   always_comb begin
      mismatch  = 1'b0;
      err_nxt   = err_cnt;
      first_nxt = first_err_vec;
      seq_nxt   = seq_err;
      if (accept) begin
         mismatch = (s_out != TT[s_vec]);
`ifdef TTC_ANY_ORDER_EN
         if (seen[s_vec])
            seq_nxt = 1'b1;
`else
         if (s_vec != idx)
            seq_nxt = 1'b1;
`endif
      end
      if (mismatch) begin
         if (err_cnt != '1)
            err_nxt = err_cnt + 1'b1;
         if (err_cnt == '0)
            first_nxt = s_vec;
      end
   end

`ifdef TTC_ANY_ORDER_EN
   always_comb begin
      seen_nxt = seen;
      if (accept)
         seen_nxt[s_vec] = 1'b1;
      pass_nxt = (err_nxt == '0) && !seq_nxt && (&seen_nxt);
   end
`else
   assign pass_nxt = (err_nxt == '0) && !seq_nxt;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state         <= IDLE;
         s_ready       <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_cnt       <= '0;
         seq_err       <= 1'b0;
         first_err_vec <= '0;
         idx           <= '0;
`ifdef TTC_ANY_ORDER_EN
         seen          <= '0;
`endif
      end else if (start) begin
         // start outranks a coincident accept: that sample is dropped
         state         <= RUN;
         s_ready       <= 1'b1;
         busy          <= 1'b1;
         done          <= 1'b0;
         pass          <= 1'b0;
         err_cnt       <= '0;
         seq_err       <= 1'b0;
         first_err_vec <= '0;
         idx           <= '0;
`ifdef TTC_ANY_ORDER_EN
         seen          <= '0;
`endif
      end else if (state == RUN && accept) begin
         err_cnt       <= err_nxt;
         first_err_vec <= first_nxt;
         seq_err       <= seq_nxt;
         idx           <= idx + 1'b1;
`ifdef TTC_ANY_ORDER_EN
         seen          <= seen_nxt;
`endif
         if (idx == IDX_LAST) begin
            state   <= DONE;
            s_ready <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
            pass    <= pass_nxt;
         end
      end
   end

endmodule

// File: tb/tb_truth_table_checker.sv
// Directed bench for truth_table_checker (N_IN=4, and_4 table); expected values hand-derived.
// A second instance with ERR_W=2 shares the stimulus to cover counter saturation.
module tb_truth_table_checker;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        s_valid;
   logic [3:0]  s_vec;
   logic        s_out;
   logic        s_ready_a, busy_a, done_a, pass_a, seq_err_a;
   logic [7:0]  err_cnt_a;
   logic [3:0]  first_a;
   logic        s_ready_b, busy_b, done_b, pass_b, seq_err_b;
   logic [1:0]  err_cnt_b;
   logic [3:0]  first_b;

   int checks = 0;
   int errors = 0;
   int acc_cnt = 0;
   bit gaps = 0;

   truth_table_checker #(.N_IN(4), .TT(16'h8000), .ERR_W(8)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready_a),
      .s_vec(s_vec), .s_out(s_out), .busy(busy_a), .done(done_a), .pass(pass_a),
      .err_cnt(err_cnt_a), .seq_err(seq_err_a), .first_err_vec(first_a)
   );

   truth_table_checker #(.N_IN(4), .TT(16'h8000), .ERR_W(2)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start), .s_valid(s_valid), .s_ready(s_ready_b),
      .s_vec(s_vec), .s_out(s_out), .busy(busy_b), .done(done_b), .pass(pass_b),
      .err_cnt(err_cnt_b), .seq_err(seq_err_b), .first_err_vec(first_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk)
      if (s_valid && s_ready_a && !start)
         acc_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   // presents one sample and returns 1 time unit after the edge that accepted it
   task automatic send(input logic [3:0] v, input logic o);
      int n = 0;
      if (gaps) repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      s_valid = 1'b1;
      s_vec   = v;
      s_out   = o;
      do begin
         @(negedge clk);
         n++;
      end while (!s_ready_a && n < 50);
      if (!s_ready_a) begin
         chk("send_timeout", 32'(s_ready_a), 32'd1);
      end else begin
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      s_vec   = 'x;
      s_out   = 'x;
   endtask

   task automatic sweep(input logic [15:0] flip);
      for (int v = 0; v < 16; v++)
         send(4'(v), (v == 15) ^ flip[v]);
   endtask

   task automatic check_result(input string tag, input logic p, input logic [7:0] e,
                               input logic s, input logic [3:0] f);
      chk({tag, "_done"},  32'(done_a),    32'd1);
      chk({tag, "_busy"},  32'(busy_a),    32'd0);
      chk({tag, "_pass"},  32'(pass_a),    32'(p));
      chk({tag, "_err"},   32'(err_cnt_a), 32'(e));
      chk({tag, "_seq"},   32'(seq_err_a), 32'(s));
      chk({tag, "_first"}, 32'(first_a),   32'(f));
   endtask

   initial begin
      rst_n   = 1'b0;
      start   = 1'b0;
      s_valid = 1'b0;
      s_vec   = '0;
      s_out   = 1'b0;
      #3;
      chk("rst_ready", 32'(s_ready_a), 32'd0);
      chk("rst_busy",  32'(busy_a),    32'd0);
      chk("rst_done",  32'(done_a),    32'd0);
      chk("rst_pass",  32'(pass_a),    32'd0);
      chk("rst_err",   32'(err_cnt_a), 32'd0);
      chk("rst_seq",   32'(seq_err_a), 32'd0);
      chk("rst_first", 32'(first_a),   32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (2) @(posedge clk);
      chk("idle_ready", 32'(s_ready_a), 32'd0);

      // clean and_4 sweep
      pulse_start();
      chk("run_busy",  32'(busy_a),    32'd1);
      chk("run_ready", 32'(s_ready_a), 32'd1);
      sweep(16'h0000);
      check_result("clean", 1'b1, 8'd0, 1'b0, 4'd0);
      chk("clean_ready", 32'(s_ready_a), 32'd0);

      // wrong outputs on vectors 3 and 9
      pulse_start();
      chk("restart_done", 32'(done_a), 32'd0);
      sweep(16'h0208);
      check_result("two_err", 1'b0, 8'd2, 1'b0, 4'd3);

      // swapped order 0,1,2,4,3,5..15
      pulse_start();
      send(4'd0, 1'b0); send(4'd1, 1'b0); send(4'd2, 1'b0);
      send(4'd4, 1'b0); send(4'd3, 1'b0);
      for (int v = 5; v < 16; v++) send(4'(v), v == 15);
`ifdef TTC_ANY_ORDER_EN
      check_result("swap", 1'b1, 8'd0, 1'b0, 4'd0);
`else
      check_result("swap", 1'b0, 8'd0, 1'b1, 4'd0);
`endif

      // vector 2 sent twice, 3 never
      pulse_start();
      send(4'd0, 1'b0); send(4'd1, 1'b0); send(4'd2, 1'b0); send(4'd2, 1'b0);
      for (int v = 4; v < 16; v++) send(4'(v), v == 15);
      check_result("dup", 1'b0, 8'd0, 1'b1, 4'd0);

      // all outputs inverted, random gaps, ERR_W=2 saturates
      pulse_start();
      acc_cnt = 0;
      gaps = 1;
      sweep(16'hFFFF);
      gaps = 0;
      check_result("inv", 1'b0, 8'd16, 1'b0, 4'd0);
      chk("inv_sat_b",  32'(err_cnt_b), 32'd3);
      chk("inv_pass_b", 32'(pass_b),    32'd0);
      s_valid = 1'b1;
      s_vec   = 4'd0;
      s_out   = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("inv_accepts", 32'(acc_cnt),   32'd16);
      chk("inv_ready",   32'(s_ready_a), 32'd0);
      chk("inv_hold",    32'(err_cnt_a), 32'd16);
      s_valid = 1'b0;

      // asynchronous reset after 7 accepts, one of them wrong
      pulse_start();
      for (int v = 0; v < 7; v++) send(4'(v), v == 2);
      chk("mid_err_pre", 32'(err_cnt_a), 32'd1);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1;
      chk("mid_busy",  32'(busy_a),    32'd0);
      chk("mid_err",   32'(err_cnt_a), 32'd0);
      chk("mid_first", 32'(first_a),   32'd0);
      chk("mid_ready", 32'(s_ready_a), 32'd0);
      @(posedge clk);
      #1 rst_n = 1'b1;
      pulse_start();
      sweep(16'h0000);
      check_result("after_rst", 1'b1, 8'd0, 1'b0, 4'd0);

      // start coincident with accept of sample 10 (sent with a wrong output)
      pulse_start();
      for (int v = 0; v < 10; v++) send(4'(v), 1'b0);
      s_valid = 1'b1;
      s_vec   = 4'd10;
      s_out   = 1'b1;
      start   = 1'b1;
      @(posedge clk);
      #1;
      start   = 1'b0;
      s_valid = 1'b0;
      chk("coll_busy", 32'(busy_a),    32'd1);
      chk("coll_err",  32'(err_cnt_a), 32'd0);
      sweep(16'h0000);
      check_result("coll", 1'b1, 8'd0, 1'b0, 4'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
